// File: rtl/nios2_irq_aggregator_pkg.sv
// Shared constants for the Nios II interrupt aggregator: register map,
// per-line mode encodings and the architectural line limit.
package nios2_irq_pkg;
  localparam int IRQ_MAX_LINES = 16;
  localparam int IRQ_IDX_W     = 4;

  localparam logic [2:0] IRQ_ADDR_PENDING = 3'd0;
  localparam logic [2:0] IRQ_ADDR_MASK    = 3'd1;
  localparam logic [2:0] IRQ_ADDR_MODE    = 3'd2;
  localparam logic [2:0] IRQ_ADDR_ACTIVE  = 3'd3;
  localparam logic [2:0] IRQ_ADDR_VECTOR  = 3'd4;
  localparam logic [2:0] IRQ_ADDR_RAW     = 3'd5;
  localparam logic [2:0] IRQ_ADDR_SWSET   = 3'd6;

  localparam logic IRQ_MODE_LEVEL = 1'b0;
  localparam logic IRQ_MODE_EDGE  = 1'b1;
endpackage

// File: rtl/nios2_irq_aggregator_if.sv
// Avalon-MM slave bus bundle for the interrupt aggregator register file.
interface nios2_irq_aggregator_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/nios2_irq_aggregator_prio_enc.sv
// Combinational lowest-set-bit encoder; bit 0 has the highest priority.
module nios2_irq_prio_enc
  import nios2_irq_pkg::*;
#(
  parameter int WIDTH = IRQ_MAX_LINES
) (
  input  logic [WIDTH-1:0]     req,
  output logic                 valid,
  output logic [IRQ_IDX_W-1:0] index
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    valid = |req;
    index = {IRQ_IDX_W{1'b0}};
    for (int i = WIDTH - 1; i >= 0; i--) begin
      index = req[i] ? IRQ_IDX_W'(i) : index;
    end
  end

endmodule

// File: rtl/nios2_irq_aggregator.sv
// Avalon-MM interrupt aggregator: per-line level/edge capture, masking and a
// prioritized single irq output with the winning line index.
module nios2_irq_aggregator
  import nios2_irq_pkg::*;
#(
  parameter int NUM_IRQ = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  nios2_irq_aggregator_if.slave         bus,
  input  logic [NUM_IRQ-1:0]            irq_in,
  output logic                          irq,
  output logic [IRQ_IDX_W-1:0]          irq_index
);

  logic [NUM_IRQ-1:0]   in_s_r, in_d_r, pending_r, mask_r, mode_r;
  logic [NUM_IRQ-1:0]   pending_nxt_s, mask_nxt_s, mode_nxt_s, mode_chg_s;
  logic [NUM_IRQ-1:0]   active_s, edge_evt_s, wd_s, sw_set_s, sw_clr_s;
  logic                 wr_s, enc_valid_s, unused_wd_s;
  logic [IRQ_IDX_W-1:0] enc_index_s;
  logic [15:0]          rd_mux_s;

  assign wr_s        = bus.chipselect & ~bus.write_n;
  assign wd_s        = bus.writedata[NUM_IRQ-1:0];
  assign unused_wd_s = ^bus.writedata;
  assign active_s    = pending_r & mask_r;
  assign edge_evt_s  = in_s_r & ~in_d_r;
  assign sw_set_s    = (wr_s && bus.address == IRQ_ADDR_SWSET)   ? wd_s : {NUM_IRQ{1'b0}};
  assign sw_clr_s    = (wr_s && bus.address == IRQ_ADDR_PENDING) ? wd_s : {NUM_IRQ{1'b0}};

  nios2_irq_prio_enc #(.WIDTH(NUM_IRQ)) u_prio_enc (
    .req   (active_s),
    .valid (enc_valid_s),
    .index (enc_index_s)
  );

  // Register-file writes and per-line pending update; a mode change wipes the line.
  always_comb begin
    mask_nxt_s    = mask_r;
    mode_nxt_s    = mode_r;
    mode_chg_s    = {NUM_IRQ{1'b0}};
    pending_nxt_s = {NUM_IRQ{1'b0}};
    if (wr_s) begin
      case (bus.address)
        IRQ_ADDR_MASK: mask_nxt_s = wd_s;
        IRQ_ADDR_MODE: begin
          mode_nxt_s = wd_s;
          mode_chg_s = wd_s ^ mode_r;
        end
        default: mask_nxt_s = mask_r;
      endcase
    end else begin
      mask_nxt_s = mask_r;
    end
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (mode_chg_s[i]) begin
        pending_nxt_s[i] = 1'b0;
      end else if (mode_r[i] == IRQ_MODE_EDGE) begin
        pending_nxt_s[i] = edge_evt_s[i] | sw_set_s[i] | (pending_r[i] & ~sw_clr_s[i]);
      end else begin
        pending_nxt_s[i] = in_s_r[i];
      end
    end
  end

  // Read mux, evaluated every cycle regardless of chipselect.
  always_comb begin
    rd_mux_s = 16'h0000;
    case (bus.address)
      IRQ_ADDR_PENDING: rd_mux_s = 16'(pending_r);
      IRQ_ADDR_MASK:    rd_mux_s = 16'(mask_r);
      IRQ_ADDR_MODE:    rd_mux_s = 16'(mode_r);
      IRQ_ADDR_ACTIVE:  rd_mux_s = 16'(active_s);
      IRQ_ADDR_VECTOR:  rd_mux_s = {enc_valid_s, 11'b000_0000_0000, enc_index_s};
      IRQ_ADDR_RAW:     rd_mux_s = 16'(in_s_r);
      default:          rd_mux_s = 16'h0000;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_s_r       <= {NUM_IRQ{1'b0}};
      in_d_r       <= {NUM_IRQ{1'b0}};
      pending_r    <= {NUM_IRQ{1'b0}};
      mask_r       <= {NUM_IRQ{1'b0}};
      mode_r       <= {NUM_IRQ{1'b0}};
      irq          <= 1'b0;
      irq_index    <= {IRQ_IDX_W{1'b0}};
      bus.readdata <= 16'h0000;
    end else begin
      in_s_r       <= irq_in;
      in_d_r       <= in_s_r;
      pending_r    <= pending_nxt_s;
      mask_r       <= mask_nxt_s;
      mode_r       <= mode_nxt_s;
      irq          <= enc_valid_s;
      irq_index    <= enc_index_s;
      bus.readdata <= rd_mux_s;
    end
  end

endmodule

// File: tb/tb_nios2_irq_aggregator.sv
// Directed plus randomized bench for nios2_irq_aggregator against a line-level
// reference model built from the sampled input history.
module tb_nios2_irq_aggregator;
  import nios2_irq_pkg::*;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] irq_in;
  logic         irq;
  logic [3:0]   irq_index;

  nios2_irq_aggregator_if bus ();

  nios2_irq_aggregator #(.NUM_IRQ(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .irq_in    (irq_in),
    .irq       (irq),
    .irq_index (irq_index)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: h1 = newest sample of irq_in, h2 = the one before.
  logic [N-1:0] h1, h2, m_pend, m_mask, m_mode;
  logic         m_irq;
  logic [3:0]   m_idx;
  logic [15:0]  m_rd;
  logic [15:0]  rv;

  function automatic logic [3:0] lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) begin
      if (v[i]) return 4'(i);
    end
    return 4'd0;
  endfunction

  function automatic logic [15:0] reg_value(input logic [2:0] a);
    logic [N-1:0] act;
    act = m_pend & m_mask;
    case (a)
      3'd0:    return 16'(m_pend);
      3'd1:    return 16'(m_mask);
      3'd2:    return 16'(m_mode);
      3'd3:    return 16'(act);
      3'd4:    return {(act != '0), 11'd0, lowest(act)};
      3'd5:    return 16'(h1);
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_edge();
    logic [N-1:0] nxt, wd;
    logic         wr;
    if (reset) begin
      h1 = '0; h2 = '0; m_pend = '0; m_mask = '0; m_mode = '0;
      m_irq = 1'b0; m_idx = 4'd0; m_rd = 16'h0000;
      return;
    end
    m_rd  = reg_value(bus.address);
    m_irq = ((m_pend & m_mask) != '0);
    m_idx = lowest(m_pend & m_mask);
    wr = bus.chipselect && !bus.write_n;
    wd = bus.writedata[N-1:0];
    for (int i = 0; i < N; i++) begin
      if (wr && bus.address == 3'd2 && wd[i] != m_mode[i])
        nxt[i] = 1'b0;
      else if (!m_mode[i])
        nxt[i] = h1[i];
      else
        nxt[i] = (h1[i] && !h2[i]) || (wr && bus.address == 3'd6 && wd[i])
                 || (m_pend[i] && !(wr && bus.address == 3'd0 && wd[i]));
    end
    m_pend = nxt;
    if (wr && bus.address == 3'd1) m_mask = wd;
    if (wr && bus.address == 3'd2) m_mode = wd;
    h2 = h1;
    h1 = irq_in;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("model_irq", 16'(irq), 16'(m_irq));
    check("model_idx", 16'(irq_index), 16'(m_idx));
    check("model_rdata", bus.readdata, m_rd);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = a; bus.writedata = d;
    tick();
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] d);
    bus.chipselect = 1'b1; bus.write_n = 1'b1; bus.address = a;
    tick();
    d = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  initial begin
    reset = 1'b1; irq_in = '0;
    bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.address = 3'd0; bus.writedata = 16'h0000;
    tick(); tick();
    reset = 1'b0;

    // Reset state: every address reads zero, outputs idle.
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), rv);
      check($sformatf("reset_read_%0d", a), rv, 16'h0000);
    end
    check("reset_irq", 16'(irq), 16'h0000);
    check("reset_idx", 16'(irq_index), 16'h0000);

    // Edge mode on bit 0, one-cycle pulse.
    wr(IRQ_ADDR_MODE, 16'h0001);
    wr(IRQ_ADDR_MASK, 16'h0001);
    irq_in = 8'h01; tick(); irq_in = 8'h00;
    tick(); check("edge0_irq_n1", 16'(irq), 16'h0000);
    tick(); check("edge0_irq_n2", 16'(irq), 16'h0001);
    rd(IRQ_ADDR_VECTOR, rv); check("edge0_vector", rv, 16'h8000);
    wr(IRQ_ADDR_PENDING, 16'h0001); check("edge0_irq_at_clr", 16'(irq), 16'h0001);
    tick(); check("edge0_irq_after_clr", 16'(irq), 16'h0000);

    // Level mode on bit 3.
    wr(IRQ_ADDR_MODE, 16'h0000);
    wr(IRQ_ADDR_MASK, 16'h0008);
    irq_in = 8'h08; tick(); tick(); tick();
    check("lvl3_irq", 16'(irq), 16'h0001);
    check("lvl3_idx", 16'(irq_index), 16'h0003);
    wr(IRQ_ADDR_PENDING, 16'h0008); tick();
    check("lvl3_clr_ignored", 16'(irq), 16'h0001);
    irq_in = 8'h00; tick(); tick();
    check("lvl3_still_high", 16'(irq), 16'h0001);
    tick(); check("lvl3_dropped", 16'(irq), 16'h0000);

    // Edge bits 2 and 5 together: priority, then clear the winner.
    wr(IRQ_ADDR_MODE, 16'h0024);
    wr(IRQ_ADDR_MASK, 16'h0024);
    irq_in = 8'h24; tick(); irq_in = 8'h00; tick(); tick();
    check("prio_idx2", 16'(irq_index), 16'h0002);
    wr(IRQ_ADDR_PENDING, 16'h0004); tick();
    check("prio_idx5", 16'(irq_index), 16'h0005);
    check("prio_irq_held", 16'(irq), 16'h0001);

    // Set beats clear on edge bit 1.
    wr(IRQ_ADDR_MODE, 16'h0002);
    wr(IRQ_ADDR_MASK, 16'h0002);
    irq_in = 8'h02; tick(); irq_in = 8'h00; tick(); tick();
    rd(IRQ_ADDR_PENDING, rv); check("setclr_pre", rv, 16'h0002);
    irq_in = 8'h02; tick(); irq_in = 8'h00;
    wr(IRQ_ADDR_PENDING, 16'h0002);
    rd(IRQ_ADDR_PENDING, rv); check("setclr_set_wins", rv, 16'h0002);

    // Software set on masked edge bit 4, then unmask, then mode switch.
    wr(IRQ_ADDR_MASK, 16'h0000);
    wr(IRQ_ADDR_MODE, 16'h0010);
    wr(IRQ_ADDR_SWSET, 16'h0010);
    rd(IRQ_ADDR_PENDING, rv); check("sw_pending", rv, 16'h0010);
    rd(IRQ_ADDR_ACTIVE, rv);  check("sw_active_masked", rv, 16'h0000);
    wr(IRQ_ADDR_MASK, 16'h0010); tick();
    check("sw_irq", 16'(irq), 16'h0001);
    wr(IRQ_ADDR_MODE, 16'h0000); tick();
    check("sw_mode_irq", 16'(irq), 16'h0000);
    rd(IRQ_ADDR_PENDING, rv); check("sw_mode_pending", rv, 16'h0000);

    // Randomized traffic checked cycle by cycle against the model.
    for (int c = 0; c < 600; c++) begin
      reset          = ($urandom_range(0, 199) == 0);
      irq_in         = N'($urandom);
      bus.address    = 3'($urandom_range(0, 7));
      bus.writedata  = 16'($urandom);
      bus.chipselect = ($urandom_range(0, 3) != 0);
      bus.write_n    = ($urandom_range(0, 2) != 0);
      tick();
    end
    reset = 1'b0;
    bus.chipselect = 1'b0; bus.write_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
